// File: rtl/hazard_scoreboard_if.sv
// ID-stage request bundle and hazard response for the hazard scoreboard.
// The master drives the decoded ID instruction and pipeline controls; the
// slave (the scoreboard) answers with the stall decision and its counter.
interface hazard_scoreboard_if #(
  parameter int AW = 4,
  parameter int CW = 16
);
  logic          id_valid;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic          two_src;
  logic          id_wb_en;
  logic          id_mem_r_en;
  logic [AW-1:0] id_dest;
  logic          forward_en;
  logic          flush;
  logic          freeze;
  logic          hazard;
  logic [1:0]    hazard_src;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, src1, src2, two_src, id_wb_en, id_mem_r_en, id_dest,
    output forward_en, flush, freeze,
    input  hazard, hazard_src, stall_cnt
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_wb_en, id_mem_r_en, id_dest,
    input  forward_en, flush, freeze,
    output hazard, hazard_src, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard scoreboard for an in-order pipeline.
// Tracks the destination of every instruction in the DEPTH stages after ID
// (entry 0 = EXE, entry DEPTH-1 = oldest) and stalls the ID instruction while
// one of its sources is still being produced and cannot be forwarded.
module hazard_scoreboard #(
  parameter int AW       = 4,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  // Per-stage record of an in-flight instruction.
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] wb_q, wb_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [AW-1:0]    dest_q [DEPTH];
  logic [AW-1:0]    dest_d [DEPTH];

  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic [1:0]       hsrc;
  logic             hazard;

  // Per-entry source match. Without forwarding any pending writer blocks;
  // with forwarding only a load still inside its non-forwardable window does.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    localparam bit IN_LOAD_SHADOW = (gi < LOAD_LAT);
    logic live;
    logic blocking;
    assign live     = v_q[gi] & wb_q[gi];
    assign blocking = live & (~bus.forward_en | (IN_LOAD_SHADOW & ld_q[gi]));
    assign hit1[gi] = blocking & bus.id_valid & (dest_q[gi] == bus.src1);
    assign hit2[gi] = blocking & bus.id_valid & bus.two_src &
                      (dest_q[gi] == bus.src2);
  end

  // While reset is asserted nothing may stall; a flush squashes the ID
  // instruction, so it has nothing to wait for.
  assign hsrc   = rst ? 2'b00 : {|hit2, |hit1};
  assign hazard = (|hsrc) & ~bus.flush;

  assign bus.hazard     = hazard;
  assign bus.hazard_src = hsrc;
  assign bus.stall_cnt  = stall_cnt_q;

  // Next-state of the stage records: shift toward the oldest stage and admit
  // the ID instruction (or a bubble when it is stalled, squashed or absent).
  always_comb begin
    v_d    = v_q;
    wb_d   = wb_q;
    ld_d   = ld_q;
    dest_d = dest_q;
    if (!bus.freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v_d[k]    = v_q[k-1];
        wb_d[k]   = wb_q[k-1];
        ld_d[k]   = ld_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      v_d[0]    = bus.id_valid & ~hazard & ~bus.flush;
      wb_d[0]   = bus.id_wb_en;
      ld_d[0]   = bus.id_mem_r_en;
      dest_d[0] = bus.id_dest;
    end
  end

  // Saturating count of cycles the pipeline actually spent stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.freeze && hazard && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State register; reset wins over freeze and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      wb_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      v_q         <= v_d;
      wb_q        <= wb_d;
      ld_q        <= ld_d;
      dest_q      <= dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (DEPTH=2, LOAD_LAT=1, AW=4, CW=16).
module tb_hazard_scoreboard;
  localparam int AW       = 4;
  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam int CW       = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(AW), .CW(CW)) bus ();

  hazard_scoreboard #(
    .AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       rst, fwd, valid, two, wb, ld, flush, freeze;
    logic [3:0] s1, s2, dest;
    logic       exp_h;
    logic [1:0] exp_hs;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t row(input logic r, f, v, t, w, l, fl, fr,
                               input logic [3:0] s1, s2, d,
                               input logic h, input logic [1:0] hs,
                               input logic [15:0] cnt);
    vec_t x;
    x.rst = r; x.fwd = f; x.valid = v; x.two = t; x.wb = w; x.ld = l;
    x.flush = fl; x.freeze = fr; x.s1 = s1; x.s2 = s2; x.dest = d;
    x.exp_h = h; x.exp_hs = hs; x.exp_cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst            = t.rst;
    bus.forward_en = t.fwd;
    bus.id_valid   = t.valid;
    bus.two_src    = t.two;
    bus.id_wb_en   = t.wb;
    bus.id_mem_r_en= t.ld;
    bus.flush      = t.flush;
    bus.freeze     = t.freeze;
    bus.src1       = t.s1;
    bus.src2       = t.s2;
    bus.id_dest    = t.dest;
  endtask

  // One cycle: drive at the falling edge, check combinational outputs and the
  // counter before the next rising edge.
  task automatic apply(input string tag, input vec_t t);
    @(negedge clk);
    drive(t);
    #2;
    chk({tag, " hazard"}, 32'(bus.hazard), 32'(t.exp_h));
    if (!t.flush) chk({tag, " hazard_src"}, 32'(bus.hazard_src), 32'(t.exp_hs));
    chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(t.exp_cnt));
    $display("[TB] %s rst=%0b fwd=%0b v=%0b s1=%0d s2=%0d two=%0b d=%0d fl=%0b fr=%0b -> h=%0b hs=%b cnt=%0h",
             tag, t.rst, t.fwd, t.valid, t.s1, t.s2, t.two, t.dest, t.flush, t.freeze,
             bus.hazard, bus.hazard_src, bus.stall_cnt);
  endtask

  // Reference model: a queue of in-flight instructions, youngest first.
  typedef struct { bit v, wb, ld; bit [3:0] dest; } ent_t;
  ent_t pipe[$];
  int   model_cnt;

  function automatic bit blocks(input ent_t e, input int age, input bit fwd, input bit [3:0] s);
    bit pending;
    pending = e.v && e.wb && (e.dest == s);
    if (fwd) return pending && e.ld && (age < LOAD_LAT);
    return pending;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t t;
    ent_t bubble;
    logic [1:0] hs_exp;
    logic h_exp;

    t = row(1,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'h0);
    drive(t);
    @(posedge clk);
    apply("reset", row(1,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'h0));

    //               rst f v t w l fl fr  s1 s2 d   h  hs     cnt
    tbl.push_back(row(0,0,1,0,1,0,0,0,  0, 0, 3,  0,2'b00,16'd0)); // write r3
    tbl.push_back(row(0,0,1,0,0,0,0,0,  3, 0, 0,  1,2'b01,16'd0)); // read r3
    tbl.push_back(row(0,0,1,0,0,0,0,0,  3, 0, 0,  1,2'b01,16'd1));
    tbl.push_back(row(0,0,1,0,0,0,0,0,  3, 0, 0,  0,2'b00,16'd2)); // proceeds
    tbl.push_back(row(0,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd2));
    tbl.push_back(row(1,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd2));
    tbl.push_back(row(0,1,1,0,1,1,0,0,  0, 0, 5,  0,2'b00,16'd0)); // load r5
    tbl.push_back(row(0,1,1,1,0,0,0,0,  1, 5, 0,  1,2'b10,16'd0)); // load-use src2
    tbl.push_back(row(0,1,1,1,0,0,0,0,  1, 5, 0,  0,2'b00,16'd1)); // forwardable
    tbl.push_back(row(1,1,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd1));
    tbl.push_back(row(0,1,1,0,1,0,0,0,  0, 0, 5,  0,2'b00,16'd0)); // ALU write r5
    tbl.push_back(row(0,1,1,0,0,0,0,0,  5, 0, 0,  0,2'b00,16'd0)); // forwarded
    tbl.push_back(row(0,1,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd0));
    tbl.push_back(row(0,0,1,0,1,0,0,0,  0, 0, 9,  0,2'b00,16'd0)); // write r9
    tbl.push_back(row(0,0,1,1,0,0,0,0,  9, 9, 0,  1,2'b11,16'd0)); // both srcs
    tbl.push_back(row(0,0,1,0,0,0,0,0,  9, 9, 0,  1,2'b01,16'd1)); // src2 unused
    tbl.push_back(row(0,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd2));
    tbl.push_back(row(0,0,1,0,1,0,0,0,  0, 0,15,  0,2'b00,16'd2)); // write r15
    tbl.push_back(row(0,0,1,1,0,0,0,0,  7,14, 0,  0,2'b00,16'd2)); // near misses
    tbl.push_back(row(0,0,1,0,0,0,0,0, 15, 0, 0,  1,2'b01,16'd2)); // oldest stage
    tbl.push_back(row(0,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd3));
    tbl.push_back(row(0,0,1,0,1,0,0,0,  1, 0, 0,  0,2'b00,16'd3)); // write r0
    tbl.push_back(row(0,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd3)); // id_valid=0
    tbl.push_back(row(0,0,1,0,0,0,0,0,  0, 0, 0,  1,2'b01,16'd3)); // r0 not special
    tbl.push_back(row(0,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd4));
    tbl.push_back(row(1,0,0,0,0,0,0,0,  0, 0, 0,  0,2'b00,16'd4));
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Freeze holds entries and counter; the stall completes after release.
    apply("frz_wr",  row(0,0,1,0,1,0,0,0, 0,0,2, 0,2'b00,16'd0));
    for (int i = 0; i < 3; i++)
      apply($sformatf("frz_hold%0d", i), row(0,0,1,0,0,0,0,1, 2,0,0, 1,2'b01,16'd0));
    apply("frz_rel0", row(0,0,1,0,0,0,0,0, 2,0,0, 1,2'b01,16'd0));
    apply("frz_rel1", row(0,0,1,0,0,0,0,0, 2,0,0, 1,2'b01,16'd1));
    apply("frz_go",   row(0,0,1,0,0,0,0,0, 2,0,0, 0,2'b00,16'd2));
    apply("frz_rst",  row(1,0,1,0,1,0,1,1, 0,0,0, 0,2'b00,16'd2)); // rst beats freeze
    apply("frz_post", row(0,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'd0));

    // Flush squashes the ID instruction and suppresses a real hazard.
    apply("fl_wr",   row(0,0,1,0,1,0,1,0, 0,0,7, 0,2'b00,16'd0));
    apply("fl_rd",   row(0,0,1,0,0,0,0,0, 7,0,0, 0,2'b00,16'd0));
    apply("fl_idle", row(0,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'd0));
    apply("fl_wr2",  row(0,0,1,0,1,0,0,0, 0,0,7, 0,2'b00,16'd0));
    apply("fl_kill", row(0,0,1,0,0,0,1,0, 7,0,0, 0,2'b00,16'd0));
    apply("fl_post", row(0,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'd0));

    // Saturation, then reset in the middle of a stall.
    apply("sat_idle", row(0,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'd0));
    @(posedge clk);
    #1;
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    apply("sat_wr",   row(0,0,1,0,1,0,0,0, 0,0,4, 0,2'b00,16'hFFFF));
    apply("sat_stl",  row(0,0,1,0,0,0,0,0, 4,0,0, 1,2'b01,16'hFFFF));
    apply("sat_rst",  row(1,0,1,0,0,0,0,0, 4,0,0, 0,2'b00,16'hFFFF));
    apply("sat_post", row(0,0,1,0,0,0,0,0, 4,0,0, 0,2'b00,16'd0));
    apply("rnd_rst",  row(1,0,0,0,0,0,0,0, 0,0,0, 0,2'b00,16'd0));

    // Randomized traffic against the queue model.
    bubble = '{v:1'b0, wb:1'b0, ld:1'b0, dest:4'd0};
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back(bubble);
    model_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      t.rst    = ($urandom_range(0, 39) == 0);
      t.fwd    = ((n / 64) % 2) == 1;
      t.valid  = ($urandom_range(0, 3) != 0);
      t.two    = $urandom_range(0, 1) == 1;
      t.wb     = ($urandom_range(0, 3) != 0);
      t.ld     = $urandom_range(0, 1) == 1;
      t.flush  = ($urandom_range(0, 7) == 0);
      t.freeze = ($urandom_range(0, 4) == 0);
      t.s1     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      t.s2     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      t.dest   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      drive(t);

      hs_exp = 2'b00;
      if (!t.rst && t.valid) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (blocks(pipe[k], k, t.fwd, t.s1)) hs_exp[0] = 1'b1;
          if (t.two && blocks(pipe[k], k, t.fwd, t.s2)) hs_exp[1] = 1'b1;
        end
      end
      h_exp = (hs_exp != 2'b00) && !t.flush;

      #2;
      chk($sformatf("rnd%0d hazard", n), 32'(bus.hazard), 32'(h_exp));
      if (!t.flush) chk($sformatf("rnd%0d hazard_src", n), 32'(bus.hazard_src), 32'(hs_exp));
      chk($sformatf("rnd%0d stall_cnt", n), 32'(bus.stall_cnt), 32'(model_cnt));
      $display("[TB] rnd%0d rst=%0b fwd=%0b v=%0b s1=%0d s2=%0d two=%0b d=%0d wb=%0b ld=%0b fl=%0b fr=%0b -> h=%0b hs=%b cnt=%0d",
               n, t.rst, t.fwd, t.valid, t.s1, t.s2, t.two, t.dest, t.wb, t.ld,
               t.flush, t.freeze, bus.hazard, bus.hazard_src, bus.stall_cnt);

      @(posedge clk);
      if (t.rst) begin
        for (int k = 0; k < DEPTH; k++) pipe[k] = bubble;
        model_cnt = 0;
      end else if (!t.freeze) begin
        ent_t ne;
        if (h_exp && model_cnt < 65535) model_cnt++;
        ne = bubble;
        if (t.valid && !h_exp && !t.flush)
          ne = '{v:1'b1, wb:t.wb, ld:t.ld, dest:t.dest};
        pipe.push_front(ne);
        void'(pipe.pop_back());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
